// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, default sizes and padding constant for
// the sort job controller and its output drain.
package sort_pkg;

  // Default engine geometry.
  localparam int unsigned DEF_NUMINPUTS = 16;
  localparam int unsigned DEF_WIDTH     = 16;

  // Padding word. All-ones pads sort to the top lanes, and only the real
  // word count is ever emitted, so genuine all-ones data still sorts right.
  localparam logic [DEF_WIDTH-1:0] PAD = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DRAIN
  } state_e;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_job_controller_if.sv
// sort_job_controller_if: input and output valid/ready word streams of the
// sort service. The master side feeds words and accepts sorted results; the
// slave side is the controller.
interface sort_job_controller_if
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  // Input stream (one job per in_last-terminated burst).
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // Output stream (sorted ascending, out_last on the final word).
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sort_out_drain.sv
// sort_out_drain: captures the engine's sorted vector and streams the first
// i_count words out ascending on a valid/ready port. The word under the read
// pointer is held for as long as the consumer stalls.
module sort_out_drain
  import sort_pkg::*;
#(
  parameter int unsigned NUMINPUTS = DEF_NUMINPUTS,
  parameter int unsigned WIDTH     = DEF_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_capture,
  input  logic                                i_draining,
  input  logic [cnt_width(NUMINPUTS)-1:0]     i_count,
  input  logic [NUMINPUTS*WIDTH-1:0]          i_eng_s,
  input  logic                                i_out_ready,
  output logic                                o_out_valid,
  output logic [WIDTH-1:0]                    o_out_data,
  output logic                                o_out_last,
  output logic                                o_done
);

  localparam int unsigned CNT_W = cnt_width(NUMINPUTS);
  localparam int unsigned IDX_W = (NUMINPUTS > 1) ? $clog2(NUMINPUTS) : 1;

  logic [WIDTH-1:0] r_buf [NUMINPUTS];
  logic [IDX_W-1:0] r_rd;
  logic             w_hs;
  logic             w_last;

  // Snapshot of the sorted lanes, taken once per job.
  // NOTE: r_buf has no reset. It is only observed while draining, and a
  // capture always fills it before draining starts, so clearing it would
  // only add reset fan-out to a wide register file.
  always_ff @(posedge clk) begin
    if (i_capture) begin
      for (int i = 0; i < NUMINPUTS; i++) begin
        r_buf[i] <= i_eng_s[i*WIDTH +: WIDTH];
      end
    end
  end

  // Read pointer: rewinds on capture and at job end, steps on each handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd <= '0;
    end else if (i_capture || o_done) begin
      r_rd <= '0;
    end else if (w_hs) begin
      r_rd <= r_rd + IDX_W'(1);
    end
  end

  // Output stream view of the buffer; data is forced to zero when not draining.
  always_comb begin
    w_hs        = i_draining && i_out_ready;
    w_last      = i_draining && (CNT_W'(r_rd) == (i_count - CNT_W'(1)));
    o_out_valid = i_draining;
    o_out_data  = i_draining ? r_buf[r_rd] : '0;
    o_out_last  = w_last;
    o_done      = w_hs && w_last;
  end

endmodule

// File: rtl/sort_job_controller.sv
// sort_job_controller: streaming wrapper around a parallel sorting engine.
// Gathers up to NUMINPUTS words into the engine lanes, waits LATENCY edges,
// then streams the sorted words out ascending. One job in flight.
// Optional statistics outputs (job_count, short_jobs) are built when the
// macro SORT_JOB_STATS_EN is defined.
module sort_job_controller
  import sort_pkg::*;
#(
  parameter int unsigned NUMINPUTS = DEF_NUMINPUTS,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  sort_job_controller_if.slave       s_if,
  output logic [NUMINPUTS*WIDTH-1:0] eng_x,
  input  logic [NUMINPUTS*WIDTH-1:0] eng_s,
  output logic                       busy
`ifdef SORT_JOB_STATS_EN
  ,
  output logic [15:0]                job_count,
  output logic [15:0]                short_jobs
`endif
);

  localparam int unsigned      CNT_W    = cnt_width(NUMINPUTS);
  localparam int unsigned      WAIT_W   = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMINPUTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUMINPUTS);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(LATENCY);
  localparam logic [WIDTH-1:0] LANE_PAD = {WIDTH{PAD[0]}};

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;
  logic [WIDTH-1:0]  r_lane [NUMINPUTS];

  logic w_in_ready;
  logic w_in_hs;
  logic w_close;
  logic w_capture;
  logic w_draining;
  logic w_drain_done;

  // Handshake qualifiers derived from the current state.
  always_comb begin
    w_in_ready = (r_state == IDLE) || (r_state == LOAD);
    w_in_hs    = s_if.in_valid && w_in_ready;
    // Job closes on in_last, or on the word that fills the last lane.
    w_close    = w_in_hs && (s_if.in_last || (r_count == LAST_IDX));
    w_capture  = (r_state == SORT) && (r_wait == WAIT_END);
    w_draining = (r_state == DRAIN);
  end

  assign s_if.in_ready = w_in_ready;
  assign busy          = (r_state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic for the load / sort / drain sequence.
  always_comb begin
    // NOTE: the default hold assignment comes first so no path through the
    // case leaves w_next_state unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_in_hs)      w_next_state = w_close ? SORT : LOAD;
      LOAD:    if (w_close)      w_next_state = SORT;
      SORT:    if (w_capture)    w_next_state = DRAIN;
      DRAIN:   if (w_drain_done) w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  // Engine lanes and word count: load on input handshakes, re-pad at job end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUMINPUTS; i++) begin
        r_lane[i] <= LANE_PAD;
      end
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_lane[0] <= s_if.in_data;
            for (int i = 1; i < NUMINPUTS; i++) begin
              r_lane[i] <= LANE_PAD;
            end
            r_count <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (w_in_hs) begin
            for (int i = 0; i < NUMINPUTS; i++) begin
              if (r_count == CNT_W'(i)) begin
                r_lane[i] <= s_if.in_data;
              end
            end
            r_count <= r_count + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            for (int i = 0; i < NUMINPUTS; i++) begin
              r_lane[i] <= LANE_PAD;
            end
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Engine wait counter: starts at 1 on the closing edge, runs to LATENCY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_close) begin
      r_wait <= WAIT_W'(1);
    end else if ((r_state == SORT) && !w_capture) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  for (genvar g = 0; g < NUMINPUTS; g++) begin : g_pack
    assign eng_x[g*WIDTH +: WIDTH] = r_lane[g];
  end

  sort_out_drain #(
    .NUMINPUTS (NUMINPUTS),
    .WIDTH     (WIDTH)
  ) u_drain (
    .clk         (clk),
    .reset       (reset),
    .i_capture   (w_capture),
    .i_draining  (w_draining),
    .i_count     (r_count),
    .i_eng_s     (eng_s),
    .i_out_ready (s_if.out_ready),
    .o_out_valid (s_if.out_valid),
    .o_out_data  (s_if.out_data),
    .o_out_last  (s_if.out_last),
    .o_done      (w_drain_done)
  );

`ifdef SORT_JOB_STATS_EN
  logic [15:0] r_job_count;
  logic [15:0] r_short_jobs;

  // Completed-job statistics, stepped on the final output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_job_count  <= '0;
      r_short_jobs <= '0;
    end else if (w_drain_done) begin
      r_job_count <= r_job_count + 16'd1;
      if (r_count < FULL_CNT) begin
        r_short_jobs <= r_short_jobs + 16'd1;
      end
    end
  end

  assign job_count  = r_job_count;
  assign short_jobs = r_short_jobs;
`else
  // Full-job marker is only consumed by the statistics counters.
  logic w_unused_full;
  assign w_unused_full = (r_count == FULL_CNT);
`endif

endmodule
